// File: rtl/bram_dp_pipelined.sv
// Simple-dual-port block RAM for the priority-queue tree: byte-lane writes, 1/2-stage read
// pipeline with read-valid, selectable read-during-write policy and a zero-fill sweeper.
module bram_dp_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_DEPTH      = 256,
    parameter int ADDR_WIDTH     = $clog2(RAM_DEPTH),
    parameter int LANE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             CLK,
    input  logic                             RSTn,
    input  logic                             i_write,
    input  logic [ADDR_WIDTH-1:0]            i_wrt_addr,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] i_wbe,
    input  logic [DATA_WIDTH-1:0]            i_data,
    input  logic                             i_read,
    input  logic [ADDR_WIDTH-1:0]            i_read_addr,
    input  logic                             i_clear,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             o_rvalid,
    output logic                             o_busy
);

    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 32'sd0) ? ST_CLEAR : ST_IDLE;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_LANES-1:0]  wbe
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (wbe[k]) begin
                merged[k*LANE_WIDTH +: LANE_WIDTH] = new_word[k*LANE_WIDTH +: LANE_WIDTH];
            end else begin
                merged[k*LANE_WIDTH +: LANE_WIDTH] = old_word[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return merged;
    endfunction

    logic [0:0]            state_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic                  busy_s;
    logic                  wr_in_range_s;
    logic                  rd_in_range_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] rd_data1_r;
    logic                  rd_valid1_r;

    // Storage deliberately has no reset so it maps onto vendor block RAM.
    logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

    generate
        if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lanes
            $error("bram_dp_pipelined: DATA_WIDTH must be a multiple of LANE_WIDTH");
        end
        if (RAM_DEPTH == (1 << ADDR_WIDTH)) begin : g_pow2
            assign wr_in_range_s = 1'b1;
            assign rd_in_range_s = 1'b1;
        end else begin : g_npow2
            localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);
            assign wr_in_range_s = ({1'b0, i_wrt_addr} < DEPTH_EXT);
            assign rd_in_range_s = ({1'b0, i_read_addr} < DEPTH_EXT);
        end
    endgenerate

    assign busy_s  = (state_r == ST_CLEAR);
    assign o_busy  = busy_s;
    assign wr_en_s = !busy_s && i_write && wr_in_range_s;
    assign rd_en_s = !busy_s && i_read;

    // Sweep sequencer: walks ptr_r over every word once, then returns to idle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_RESET;
            ptr_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ptr_r <= '0;
                    if (i_clear) begin
                        state_r <= ST_CLEAR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (ptr_r == LAST_ADDR) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= '0;
                    end else begin
                        state_r <= ST_CLEAR;
                        ptr_r   <= ptr_r + ONE_ADDR;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ptr_r   <= '0;
                end
            endcase
        end
    end

    // Array write port: sweep zero-fill has the port exclusively while busy.
    always_ff @(posedge CLK) begin
        if (busy_s) begin
            mem_r[ptr_r] <= '0;
        end else if (wr_en_s) begin
            mem_r[i_wrt_addr] <= merge_lanes(mem_r[i_wrt_addr], i_data, i_wbe);
        end
    end

    // Read word selection; write-first forwards only the enabled lanes of a colliding write.
    always_comb begin
        rd_word_s = '0;
        if (rd_in_range_s) begin
            if ((RDW_MODE == 32'sd1) && wr_en_s && (i_wrt_addr == i_read_addr)) begin
                rd_word_s = merge_lanes(mem_r[i_read_addr], i_data, i_wbe);
            end else begin
                rd_word_s = mem_r[i_read_addr];
            end
        end else begin
            rd_word_s = '0;
        end
    end

    // First read stage; data only reloads on an accepted read so it holds otherwise.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_valid1_r <= 1'b0;
            rd_data1_r  <= '0;
        end else begin
            rd_valid1_r <= rd_en_s;
            if (rd_en_s) begin
                rd_data1_r <= rd_word_s;
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign o_rdata  = rd_data1_r;
            assign o_rvalid = rd_valid1_r;
        end else if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd_data2_r;
            logic                  rd_valid2_r;

            // Optional output register stage, same hold-on-idle behaviour.
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    rd_valid2_r <= 1'b0;
                    rd_data2_r  <= '0;
                end else begin
                    rd_valid2_r <= rd_valid1_r;
                    if (rd_valid1_r) begin
                        rd_data2_r <= rd_data1_r;
                    end
                end
            end

            assign o_rdata  = rd_data2_r;
            assign o_rvalid = rd_valid2_r;
        end else begin : g_bad_latency
            $error("bram_dp_pipelined: READ_LATENCY must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_bram_dp_pipelined.sv
// Bench for bram_dp_pipelined: two instances (256/lat1/read-first/auto-clear and
// 200/lat2/write-first/no-auto-clear) share stimulus and are checked against a queue-based model.
`timescale 1ns/1ps
module tb_bram_dp_pipelined;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        i_write;
    logic [7:0]  i_wrt_addr;
    logic [3:0]  i_wbe;
    logic [31:0] i_data;
    logic        i_read;
    logic [7:0]  i_read_addr;
    logic        i_clear;
    logic [31:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, busy_a, busy_b;

    always #5 CLK = ~CLK;

    bram_dp_pipelined #(.RAM_DEPTH(256), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
        .CLK(CLK), .RSTn(RSTn), .i_write(i_write), .i_wrt_addr(i_wrt_addr), .i_wbe(i_wbe),
        .i_data(i_data), .i_read(i_read), .i_read_addr(i_read_addr), .i_clear(i_clear),
        .o_rdata(rdata_a), .o_rvalid(rvalid_a), .o_busy(busy_a));

    bram_dp_pipelined #(.RAM_DEPTH(200), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(0)) u_b (
        .CLK(CLK), .RSTn(RSTn), .i_write(i_write), .i_wrt_addr(i_wrt_addr), .i_wbe(i_wbe),
        .i_data(i_data), .i_read(i_read), .i_read_addr(i_read_addr), .i_clear(i_clear),
        .o_rdata(rdata_b), .o_rvalid(rvalid_b), .o_busy(busy_b));

    typedef struct {
        logic        wr;
        logic [7:0]  waddr;
        logic [3:0]  wbe;
        logic [31:0] wdata;
        logic        rd;
        logic [7:0]  raddr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
    } pend_t;

    // Reference model: word arrays, remaining-sweep counters, and a list of reads due at an edge.
    logic [31:0] m_mem [2][256];
    int          m_busy [2];
    logic [31:0] m_last [2];
    pend_t       pend [$];
    int          edge_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cap [2];
    int          nvalid [2];
    vec_t        vecs [18];

    function automatic int depth_of(input int i);
        return (i == 0) ? 256 : 200;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] wbe);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (wbe[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %h expected %h (t=%0t)", name, inst, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] old_w, d;
        int          dep;
        edge_cnt++;
        for (int i = 0; i < 2; i++) begin
            dep = depth_of(i);
            if (!RSTn) begin
                m_busy[i] = (i == 0) ? 256 : 0;
                m_last[i] = 32'h0;
            end else if (m_busy[i] > 0) begin
                m_mem[i][dep - m_busy[i]] = 32'h0;
                m_busy[i]--;
            end else begin
                if (i_read) begin
                    old_w = (int'(i_read_addr) < dep) ? m_mem[i][i_read_addr] : 32'h0;
                    d = old_w;
                    if (i == 1 && i_write && i_wrt_addr == i_read_addr && int'(i_wrt_addr) < dep)
                        d = merge(old_w, i_data, i_wbe);
                    pend.push_back('{i, edge_cnt + lat_of(i) - 1, d});
                end
                if (i_write && int'(i_wrt_addr) < dep)
                    m_mem[i][i_wrt_addr] = merge(m_mem[i][i_wrt_addr], i_data, i_wbe);
                if (i_clear) m_busy[i] = dep;
            end
        end
        if (!RSTn) pend.delete();
    endtask

    task automatic check_outputs();
        logic        exp_v, got_v, got_b;
        logic [31:0] exp_d, got_d;
        for (int i = 0; i < 2; i++) begin
            exp_v = 1'b0;
            exp_d = m_last[i];
            foreach (pend[j]) if (pend[j].inst == i && pend[j].due == edge_cnt) begin
                exp_v = 1'b1;
                exp_d = pend[j].data;
            end
            got_v = (i == 0) ? rvalid_a : rvalid_b;
            got_d = (i == 0) ? rdata_a : rdata_b;
            got_b = (i == 0) ? busy_a : busy_b;
            chk("model_rvalid", i, {31'b0, got_v}, {31'b0, exp_v});
            chk("model_rdata", i, got_d, exp_d);
            chk("model_busy", i, {31'b0, got_b}, {31'b0, m_busy[i] > 0});
            if (got_v === 1'b1) begin
                cap[i] = got_d;
                nvalid[i]++;
            end
            m_last[i] = exp_d;
        end
        for (int j = pend.size() - 1; j >= 0; j--) if (pend[j].due <= edge_cnt) pend.delete(j);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        i_write = 1'b0; i_wrt_addr = 8'd0; i_wbe = 4'h0; i_data = 32'h0;
        i_read = 1'b0; i_read_addr = 8'd0; i_clear = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [7:0] wa, input logic [3:0] be,
                         input logic [31:0] wd, input logic rd, input logic [7:0] ra);
        i_write = wr; i_wrt_addr = wa; i_wbe = be; i_data = wd; i_read = rd; i_read_addr = ra;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        nvalid[0] = 0;
        nvalid[1] = 0;
        drive(v.wr, v.waddr, v.wbe, v.wdata, v.rd, v.raddr);
        cycle();
        idle();
        cycle();
        cycle();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("vec%0d_nvalid", idx), i, 32'(nvalid[i]), v.rd ? 32'd1 : 32'd0);
            if (v.rd) chk($sformatf("vec%0d_data", idx), i, cap[i], (i == 0) ? v.exp_a : v.exp_b);
        end
    endtask

    initial begin
        int ea, eb, na, nb;
        vec_t v;

        //           wr    waddr   wbe   wdata          rd    raddr   exp_a          exp_b
        vecs[0]  = '{1'b1, 8'd5,   4'hF, 32'hDEADBEEF, 1'b0, 8'd0,   32'h0,         32'h0};
        vecs[1]  = '{1'b1, 8'd5,   4'h3, 32'h00001234, 1'b0, 8'd0,   32'h0,         32'h0};
        vecs[2]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd5,   32'hDEAD1234,  32'hDEAD1234};
        vecs[3]  = '{1'b1, 8'd7,   4'hF, 32'h11111111, 1'b0, 8'd0,   32'h0,         32'h0};
        vecs[4]  = '{1'b1, 8'd7,   4'hF, 32'hA5A5A5A5, 1'b1, 8'd7,   32'h11111111,  32'hA5A5A5A5};
        vecs[5]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd7,   32'hA5A5A5A5,  32'hA5A5A5A5};
        vecs[6]  = '{1'b1, 8'd7,   4'h2, 32'h0000CC00, 1'b1, 8'd7,   32'hA5A5A5A5,  32'hA5A5CCA5};
        vecs[7]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd7,   32'hA5A5CCA5,  32'hA5A5CCA5};
        vecs[8]  = '{1'b1, 8'd250, 4'hF, 32'hCAFEF00D, 1'b1, 8'd250, 32'h0,         32'h0};
        vecs[9]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd250, 32'hCAFEF00D,  32'h0};
        vecs[10] = '{1'b1, 8'd199, 4'hF, 32'h12345678, 1'b0, 8'd0,   32'h0,         32'h0};
        vecs[11] = '{1'b1, 8'd250, 4'hF, 32'h87654321, 1'b1, 8'd199, 32'h12345678,  32'h12345678};
        vecs[12] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd199, 32'h12345678,  32'h12345678};
        vecs[13] = '{1'b1, 8'd0,   4'h0, 32'hFFFFFFFF, 1'b1, 8'd0,   32'h0,         32'h0};
        vecs[14] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd0,   32'h0,         32'h0};
        vecs[15] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd128, 32'h0,         32'h0};
        vecs[16] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd255, 32'h0,         32'h0};
        vecs[17] = '{1'b1, 8'd10,  4'hF, 32'hAAAA5555, 1'b1, 8'd5,   32'hDEAD1234,  32'hDEAD1234};

        RSTn = 1'b0;
        idle();
        cycle();
        cycle();
        RSTn = 1'b1;

        // u_a sweeps from release (idle on edge 256); u_b sweeps from the clear taken on edge 1.
        ea = -1;
        eb = -1;
        for (int n = 1; n <= 400; n++) begin
            idle();
            if (n == 1) i_clear = 1'b1;
            if (n == 2) drive(1'b1, 8'd9, 4'hF, 32'h00000077, 1'b1, 8'd9);
            if (n == 100) i_clear = 1'b1;
            cycle();
            if (ea < 0 && busy_a === 1'b0) ea = n;
            if (eb < 0 && busy_b === 1'b0) eb = n;
            if (ea >= 0 && eb >= 0) break;
        end
        chk("reset_sweep_edges", 0, 32'(ea), 32'd256);
        chk("clear_sweep_edges", 1, 32'(eb), 32'd201);
        idle();
        cycle();

        for (int k = 0; k < 18; k++) apply_vec(vecs[k], k);

        // Back-to-back reads through both pipelines.
        drive(1'b1, 8'd1, 4'hF, 32'h10, 1'b0, 8'd0); cycle();
        drive(1'b1, 8'd2, 4'hF, 32'h20, 1'b0, 8'd0); cycle();
        drive(1'b1, 8'd3, 4'hF, 32'h30, 1'b0, 8'd0); cycle();
        drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd1); cycle();
        chk("l2_e0_va", 0, {31'b0, rvalid_a}, 32'd1); chk("l2_e0_da", 0, rdata_a, 32'h10);
        chk("l2_e0_vb", 1, {31'b0, rvalid_b}, 32'd0);
        drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd2); cycle();
        chk("l2_e1_da", 0, rdata_a, 32'h20);
        chk("l2_e1_vb", 1, {31'b0, rvalid_b}, 32'd1); chk("l2_e1_db", 1, rdata_b, 32'h10);
        drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd3); cycle();
        chk("l2_e2_da", 0, rdata_a, 32'h30);
        chk("l2_e2_vb", 1, {31'b0, rvalid_b}, 32'd1); chk("l2_e2_db", 1, rdata_b, 32'h20);
        idle(); cycle();
        chk("l2_e3_va", 0, {31'b0, rvalid_a}, 32'd0);
        chk("l2_e3_vb", 1, {31'b0, rvalid_b}, 32'd1); chk("l2_e3_db", 1, rdata_b, 32'h30);
        cycle();
        chk("l2_e4_vb", 1, {31'b0, rvalid_b}, 32'd0); chk("l2_e4_hold", 1, rdata_b, 32'h30);

        // Clear request: follow-up write dropped, second clear mid-sweep ignored.
        drive(1'b1, 8'd9, 4'hF, 32'h00000099, 1'b0, 8'd0); cycle();
        na = 0;
        nb = 0;
        for (int n = 0; n < 400; n++) begin
            idle();
            if (n == 0) i_clear = 1'b1;
            if (n == 1) drive(1'b1, 8'd9, 4'hF, 32'h00000077, 1'b1, 8'd9);
            if (n == 120) i_clear = 1'b1;
            cycle();
            if (busy_a === 1'b1) na++;
            if (busy_b === 1'b1) nb++;
            if (busy_a === 1'b0 && busy_b === 1'b0) break;
        end
        chk("clear_busy_cycles", 0, 32'(na), 32'd256);
        chk("clear_busy_cycles", 1, 32'(nb), 32'd200);
        idle();
        v = '{1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd9, 32'h0, 32'h0};
        apply_vec(v, 100);

        // Reset in the middle of a sweep restarts u_a's sweep from address 0.
        i_clear = 1'b1; cycle(); idle();
        repeat (50) cycle();
        RSTn = 1'b0;
        cycle();
        RSTn = 1'b1;
        ea = -1;
        for (int n = 1; n <= 400; n++) begin
            cycle();
            if (busy_a === 1'b0) begin
                ea = n;
                break;
            end
        end
        chk("rst_restart_edges", 0, 32'(ea), 32'd256);

        for (int n = 0; n < 2500; n++) begin
            i_write     = 1'($urandom_range(0, 1));
            i_wrt_addr  = 8'($urandom_range(0, 255));
            i_wbe       = 4'($urandom_range(0, 15));
            i_data      = $urandom;
            i_read      = 1'($urandom_range(0, 1));
            i_read_addr = ($urandom_range(0, 1) == 1) ? i_wrt_addr : 8'($urandom_range(0, 255));
            i_clear     = ($urandom_range(0, 599) == 0);
            cycle();
        end
        idle();
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_dp_pipelined.md
Name: bram_dp_pipelined

Overview:
Parametrised simple-dual-port block RAM for the BRAM-tree priority-queue storage. It adds several features to the plain single-cycle RAM:
- configurable read latency (1 or 2 register stages)
- read-during-write collision policy
- per-lane write enables
- read-valid tracking
- a built-in clear sequencer that zero-fills the array after reset or on request.

Memory contents are not reset by RSTn, so the array still maps to vendor BRAM. Zeroing is done by the sequencer.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH
RAM_DEPTH, 256, number of words; any value >= 2
ADDR_WIDTH, $clog2(RAM_DEPTH), address width (derived, not overridden)
LANE_WIDTH, 8, bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH
READ_LATENCY, 1, 1 or 2; edges from accepted read to o_rvalid; other values are an elaboration error
RDW_MODE, 0, same-address read/write policy: 0 = read-first (old data), 1 = write-first (new data)
CLEAR_ON_RESET, 1, 1 = sequencer zero-fills the array automatically after RSTn deasserts

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  asynchronous active-low reset
i_write  input  1  write request
i_wrt_addr  input  ADDR_WIDTH  write address
i_wbe  input  NUM_LANES  per-lane write enable; lane k = bits [k*LANE_WIDTH +: LANE_WIDTH]
i_data  input  DATA_WIDTH  write data
i_read  input  1  read request
i_read_addr  input  ADDR_WIDTH  read address
i_clear  input  1  single-cycle pulse to start a zero-fill sweep
o_rdata  output  DATA_WIDTH  read data
o_rvalid  output  1  o_rdata holds the result of an accepted read this cycle
o_busy  output  1  clear sweep in progress; user read and write are ignored

Behaviour:
- Clock and reset: CLK, rising edge; RSTn asynchronous, active-low.
- Reset values: o_rdata = 0, o_rvalid = 0, pipeline valid bits = 0, sweep pointer = 0.
- Reset FSM state: CLEAR if CLEAR_ON_RESET = 1, else IDLE. o_busy follows the FSM state, so it is 1 immediately in reset when CLEAR_ON_RESET = 1.
- Memory array has no reset. Asserting RSTn mid-sweep restarts the sweep from address 0 on release.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when i_clear = 1.
  - In CLEAR: one word is written to 0 per cycle at ptr, ptr increments.
  - CLEAR -> IDLE on the edge that writes address RAM_DEPTH-1; ptr returns to 0.
  - A sweep takes exactly RAM_DEPTH cycles with o_busy = 1. o_busy = 0 in the cycle after the last clear write.
  - i_clear while in CLEAR is ignored (no restart).
- While o_busy = 1: i_write and i_read are dropped, no o_rvalid is generated, and reads already in the pipeline still complete.
- Write (IDLE, i_write = 1, i_wrt_addr < RAM_DEPTH): lane k of ram[addr] takes i_data lane k iff i_wbe[k]. Lanes with i_wbe = 0 are unchanged. i_wbe = 0 is a legal no-op.
- Read (IDLE, i_read = 1), accepted on edge N:
  - READ_LATENCY = 1: data is on o_rdata with o_rvalid = 1 after edge N.
  - READ_LATENCY = 2: data appears after edge N+1.
  - Back-to-back reads every cycle are supported at full throughput; order is preserved.
- Out-of-range addresses (>= RAM_DEPTH, only possible when RAM_DEPTH is not a power of 2):
  - writes are ignored;
  - reads still return o_rvalid = 1 with data 0.
- o_rdata holds its last value when o_rvalid = 0. o_rvalid is a one-cycle pulse per accepted read.
- Same-cycle read and write to the same address:
  - RDW_MODE = 0: read returns the pre-write word.
  - RDW_MODE = 1: read returns the post-write word. Only enabled lanes are forwarded; the other lanes come from the old word.
- Same-cycle read and write to different addresses are independent.
- A write in cycle N is visible to a read issued in cycle N+1 or later in both modes.
- i_clear in the same cycle as i_read/i_write while IDLE: the user operations are accepted and take effect, and the FSM enters CLEAR on the same edge.

Test Plan:
- Reset with CLEAR_ON_RESET = 1, DEPTH = 256 -> o_busy = 1 for exactly 256 cycles after RSTn release; then reading addresses 0, 128, 255 each returns 0 with o_rvalid one edge later (READ_LATENCY = 1).
- Write 0xDEADBEEF to address 5, then write 0x00001234 with i_wbe = 4'b0011, then read address 5 -> o_rdata = 0xDEAD1234.
- Same-cycle write 0xA5A5A5A5 and read at address 7 (old value 0x11111111): RDW_MODE = 0 -> 0x11111111; RDW_MODE = 1 -> 0xA5A5A5A5.
- READ_LATENCY = 2: reads of addresses 1, 2, 3 on consecutive cycles (holding 0x10, 0x20, 0x30) -> o_rvalid high for 3 consecutive cycles starting 2 edges after the first read, with data 0x10, 0x20, 0x30 in order.
- i_clear pulse, then i_write to address 9 in the next cycle -> write dropped; after the sweep, address 9 reads 0. A second i_clear mid-sweep does not extend o_busy beyond RAM_DEPTH cycles.
- RAM_DEPTH = 200: read address 250 -> o_rvalid = 1, o_rdata = 0. Write to 250 followed by a reread of address 199 -> address 199 unchanged.
